// File: rtl/imem_port_arbiter_if.sv
// Instruction-memory port bundle: fetch path, loader path, CPU hold and the
// shared memory port. The arbiter takes the slave view; requesters/testbench
// take the master view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              cpu_hold;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_done,
    output fetch_stall, fetch_valid, ld_ready, cpu_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_done,
    input  fetch_stall, fetch_valid, ld_ready, cpu_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between IF fetch and the program
// loader. BOOT lets the loader own the port while the CPU is held; after
// ld_done one DRAIN cycle passes, then RUN gives fetch priority with a
// starvation counter that forces a loader grant after STARVE_MAX waits.
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_port_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_next;
  logic             r_fetch_valid;
  logic             w_ld_grant;
  logic             w_fetch_grant;
  logic             w_forced;

  // State, starvation counter and fetch-valid registers (sync active-low reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= BOOT;
      r_starve_cnt  <= '0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_starve_cnt  <= w_starve_next;
      r_fetch_valid <= w_fetch_grant;
    end
  end

  // Next state, grant decision, CPU hold and fetch stall.
  // Reset is folded in here so grants are suppressed in the reset cycle itself.
  always_comb begin
    w_next_state    = r_state;
    w_ld_grant      = 1'b0;
    w_fetch_grant   = 1'b0;
    w_forced        = (r_starve_cnt == CNT_W'(STARVE_MAX));
    bus.cpu_hold    = 1'b1;
    bus.fetch_stall = bus.fetch_req;
    if (!rst) begin
      w_next_state = BOOT;
    end else begin
      case (r_state)
        BOOT: begin
          w_ld_grant = bus.ld_valid;
          if (bus.ld_done) w_next_state = DRAIN;
        end
        DRAIN: begin
          w_next_state = RUN;
        end
        RUN: begin
          bus.cpu_hold = 1'b0;
          if (bus.ld_valid && (!bus.fetch_req || w_forced)) begin
            w_ld_grant = 1'b1;
          end else if (bus.fetch_req) begin
            w_fetch_grant = 1'b1;
          end
          bus.fetch_stall = bus.fetch_req & ~w_fetch_grant;
        end
        default: begin
          w_next_state = BOOT;
        end
      endcase
    end
  end

  // Starvation counter: counts ungranted loader cycles in RUN, saturating.
  always_comb begin
    w_starve_next = '0;
    if (rst && (r_state == RUN) && bus.ld_valid && !w_ld_grant) begin
      w_starve_next = w_forced ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
    end
  end

  // Memory port mux and handshake outputs.
  always_comb begin
    bus.ld_ready    = w_ld_grant;
    bus.fetch_valid = r_fetch_valid;
    bus.mem_en      = w_ld_grant | w_fetch_grant;
    bus.mem_we      = w_ld_grant;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    if (w_ld_grant) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_data;
    end else if (w_fetch_grant) begin
      bus.mem_addr  = bus.fetch_addr;
    end
  end

endmodule
